otter_fetch: RTL
================

# otter_fetch

Instruction-fetch stage of the pipelined OTTER core. It holds the architectural PC and selects the next PC from the branch/jump decision (`CU_PCSOURCE`) that execute produces. It issues pipelined requests to instruction memory and buffers returned instructions in a 2-entry queue for decode. On a taken redirect it squashes all wrong-path fetches, both buffered and in flight.

## Interface
Parameters:
- `RESET_VEC`, default 32'h0000_0000: PC value after reset.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: reset, asynchronous and active-low.
- `EX_VALID` in 1: execute holds a valid instruction; qualifies `CU_PCSOURCE`.
- `CU_PCSOURCE` in 4: next-PC select.
  - 0 = sequential.
  - 1 = JALR.
  - 2 = branch.
  - 3 = JAL.
  - 4–15 = treated as 0.
- `JALR_TARGET` in 32: JALR target.
- `BRANCH_TARGET` in 32: branch target.
- `JAL_TARGET` in 32: JAL target.
- `IMEM_REQ` out 1: fetch request valid.
- `IMEM_ADDR` out 32: fetch address, word aligned.
- `IMEM_RDY` in 1: memory accepts the request this cycle.
- `IMEM_RVALID` in 1: read data valid. Responses return in order, at least 1 cycle after acceptance.
- `IMEM_RDATA` in 32: instruction word.
- `IF_VALID` out 1: queue head valid toward decode.
- `IF_PC` out 32: PC of the queue head.
- `IF_IR` out 32: instruction of the queue head.
- `ID_READY` in 1: decode consumes the head this cycle.

## Operation
- **Redirect:** `redirect = EX_VALID && CU_PCSOURCE in {1,2,3}`.
  - The target is the matching *_TARGET input with bits [1:0] forced to 0.
- **PC register `pc`:**
  - On redirect: `pc <= target`.
  - Else on an accepted request (`IMEM_REQ && IMEM_RDY`): `pc <= pc + 4`, modulo 2^32 (wraps from 32'hFFFF_FFFC to 0).
  - Else: holds.
- **Address and request:**
  - `IMEM_ADDR = pc`.
  - `IMEM_REQ = !redirect && (outstanding + count - pop < 2)`.
  - `pop = IF_VALID && ID_READY`.
  - The credit limit of 2 covers requests in flight plus queued entries.
- **Request hold:** a request not yet accepted keeps the same `IMEM_ADDR` and stays asserted until accepted. The only exception is a redirect, which may drop it.
- **In-flight tracking:** a 2-entry PC queue records the address of each accepted request.
  - `outstanding` (0..2) increments on accept and decrements on `IMEM_RVALID`.
- **Instruction queue:** a 2-entry FIFO of {pc, ir}.
  - Push: on `IMEM_RVALID` when `kill == 0`. The pc comes from the in-flight queue head.
  - Pop: on `pop`.
  - Push and pop in the same cycle are both legal, including when the FIFO is full.
- **Squash on redirect:**
  - Instruction FIFO is cleared; any pop that cycle is ignored.
  - `kill` is loaded with the in-flight count after this cycle's accept/return.
  - Each later `IMEM_RVALID` with `kill > 0` decrements `kill` and is discarded.
  - A response arriving in the redirect cycle itself is discarded.
  - The in-flight PC queue keeps popping normally.
- **Outputs to decode:** `IF_VALID = count != 0`. `IF_PC`/`IF_IR` = FIFO head, driven from registers.
- **Reset state:**
  - `pc = RESET_VEC`.
  - `outstanding = count = kill = 0`.
  - `IMEM_REQ = 0` while `RST_N` is low.
  - `IF_VALID = 0`, `IF_PC = 0`, `IF_IR = 0`.
- **Reset mid-operation:** asserting reset mid-operation discards all in-flight state immediately. The memory must not return responses for requests issued before reset.

## Timing
- **First request:** on the first edge after `RST_N` rises, with `IMEM_ADDR = RESET_VEC`.
- **Fetch latency:** accept in cycle N, `IMEM_RVALID` in N+1, `IF_VALID` in N+2.
- **Throughput:** 1 instruction/cycle sustained with single-cycle memory and `ID_READY` held high. The pop-aware credit makes this possible.
- **Redirect latency:**
  - Redirect in cycle R: `IMEM_REQ = 0` in R.
  - `IMEM_ADDR = target` with `IMEM_REQ = 1` in R+1.
  - First target instruction reaches `IF_VALID` at R+3 with single-cycle memory.
- **Decode stall** (`ID_READY` low): the FIFO fills to 2 and `IMEM_REQ` deasserts.
  - `IF_PC`/`IF_IR` stay stable while `IF_VALID && !ID_READY`.
- **Back-to-back redirects** in consecutive cycles: the later one wins, and `kill` is reloaded.

## Test plan
- **Reset/stream:** `RESET_VEC=32'h100`, single-cycle memory, `ID_READY=1` -> `IF_PC` = 100,104,108,… one per cycle, starting 2 cycles after the first accept.
- **Decode stall:** hold `ID_READY=0` for 5 cycles mid-stream -> `count` saturates at 2, `IMEM_REQ=0`, head PC stable. On release the stream resumes with no gaps or duplicates.
- **Branch redirect with 2 in flight:** 2-cycle memory latency, `CU_PCSOURCE=2`, `BRANCH_TARGET=32'h200` -> both stale responses are dropped, and the next `IF_PC` is 200.
- **JALR alignment:** `CU_PCSOURCE=1`, `JALR_TARGET=32'h303` -> `IMEM_ADDR=32'h300`.
- **Unqualified or invalid select:** `CU_PCSOURCE=3` with `EX_VALID=0`, and `CU_PCSOURCE=5` with `EX_VALID=1` -> no redirect; sequential fetch continues.
- **Wrap and collisions:** `RESET_VEC=32'hFFFF_FFF8` -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. A redirect in the same cycle as `IMEM_RVALID` and `pop` -> the FIFO empties and that response is discarded.

Source files
------------

// File: rtl/otter_fetch.sv
// OTTER instruction-fetch stage: PC select, pipelined imem requests,
// in-flight address tracking and a 2-entry instruction queue for decode.
module otter_fetch #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        EX_VALID,
   input  logic [3:0]  CU_PCSOURCE,
   input  logic [31:0] JALR_TARGET,
   input  logic [31:0] BRANCH_TARGET,
   input  logic [31:0] JAL_TARGET,
   output logic        IMEM_REQ,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_RDY,
   input  logic        IMEM_RVALID,
   input  logic [31:0] IMEM_RDATA,
   output logic        IF_VALID,
   output logic [31:0] IF_PC,
   output logic [31:0] IF_IR,
   input  logic        ID_READY
);

   logic [31:0] pc_q, pc_d;
   logic [1:0]  out_q, out_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  kill_q, kill_d;

   logic [31:0] ifq_q [2];
   logic        ifq_wp_q, ifq_rp_q;

   logic [31:0] fpc_q [2];
   logic [31:0] fir_q [2];
   logic        f_wp_q, f_rp_q;

   logic        redirect;
   logic [31:0] target;
   logic        pop, do_pop, push, accept;
   logic [2:0]  used;

   always_comb begin
      redirect = 1'b0;
      target   = 32'h0;
      case (CU_PCSOURCE)
         4'd1: begin
            redirect = EX_VALID;
            target   = {JALR_TARGET[31:2], 2'b00};
         end
         4'd2: begin
            redirect = EX_VALID;
            target   = {BRANCH_TARGET[31:2], 2'b00};
         end
         4'd3: begin
            redirect = EX_VALID;
            target   = {JAL_TARGET[31:2], 2'b00};
         end
         default: begin
            redirect = 1'b0;
            target   = 32'h0;
         end
      endcase
   end

   // Credit counts in-flight plus queued, net of this cycle's pop.
   assign pop      = (cnt_q != 2'd0) && ID_READY;
   assign used     = {1'b0, out_q} + {1'b0, cnt_q} - {2'b00, pop};
   assign IMEM_REQ = RST_N && !redirect && (used < 3'd2);
   assign accept   = IMEM_REQ && IMEM_RDY;
   assign push     = IMEM_RVALID && (kill_q == 2'd0) && !redirect;
   assign do_pop   = pop && !redirect;

   assign IMEM_ADDR = pc_q;
   assign IF_VALID  = (cnt_q != 2'd0);
   assign IF_PC     = fpc_q[f_rp_q];
   assign IF_IR     = fir_q[f_rp_q];

   always_comb begin
      pc_d = pc_q;
      if (redirect)    pc_d = target;
      else if (accept) pc_d = pc_q + 32'd4;

      out_d = out_q + {1'b0, accept} - {1'b0, IMEM_RVALID};

      kill_d = kill_q;
      if (redirect)
         kill_d = out_d;
      else if (IMEM_RVALID && (kill_q != 2'd0))
         kill_d = kill_q - 2'd1;

      cnt_d = cnt_q;
      if (redirect) cnt_d = 2'd0;
      else          cnt_d = cnt_q + {1'b0, push} - {1'b0, do_pop};
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc_q     <= RESET_VEC;
         out_q    <= 2'd0;
         cnt_q    <= 2'd0;
         kill_q   <= 2'd0;
         ifq_q[0] <= 32'h0;
         ifq_q[1] <= 32'h0;
         ifq_wp_q <= 1'b0;
         ifq_rp_q <= 1'b0;
         fpc_q[0] <= 32'h0;
         fpc_q[1] <= 32'h0;
         fir_q[0] <= 32'h0;
         fir_q[1] <= 32'h0;
         f_wp_q   <= 1'b0;
         f_rp_q   <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         out_q  <= out_d;
         cnt_q  <= cnt_d;
         kill_q <= kill_d;
         if (accept) begin
            ifq_q[ifq_wp_q] <= pc_q;
            ifq_wp_q        <= ~ifq_wp_q;
         end
         if (IMEM_RVALID)
            ifq_rp_q <= ~ifq_rp_q;
         if (redirect) begin
            f_wp_q <= 1'b0;
            f_rp_q <= 1'b0;
         end else begin
            // A full queue popped and pushed together reuses the head slot.
            if (push) begin
               fpc_q[f_wp_q] <= ifq_q[ifq_rp_q];
               fir_q[f_wp_q] <= IMEM_RDATA;
               f_wp_q        <= ~f_wp_q;
            end
            if (do_pop)
               f_rp_q <= ~f_rp_q;
         end
      end
   end

endmodule
